ring_token_arbiter: RTL and testbench

//   Round-robin arbiter that shares one resource among N requesters using a one-hot

---
 rtl/ring_arb_pkg.sv | 32 +++
 rtl/ring_pointer.sv | 22 ++
 rtl/ring_token_arbiter.sv | 118 +++++++++++
 tb/tb_ring_token_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/ring_arb_pkg.sv
// Shared types and helpers for the ring token arbiter.
package ring_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    HANDOFF = 2'd2
  } state_e;

  // Widest ring the helpers can handle; callers zero-extend narrower vectors.
  localparam int MAX_N = 64;

  // Rotate a one-hot vector left by one within the low n bits; bit n-1 wraps to bit 0.
  function automatic logic [MAX_N-1:0] rotl_onehot(input logic [MAX_N-1:0] v, input int n);
    logic [MAX_N-1:0] mask;
    mask = (MAX_N'(1) << n) - MAX_N'(1);
    return ((v << 1) | (v >> (n - 1))) & mask;
  endfunction

  // Binary index of the set bit of a one-hot vector; 0 for an all-zero vector.
  function automatic int onehot2bin(input logic [MAX_N-1:0] v);
    logic [MAX_N-1:0] t;
    int r;
    r = 0;
    for (int i = 0; i < MAX_N; i++) begin
      t = v >> i;
      if (t[0]) r = r | i;
    end
    return r;
  endfunction

endpackage

// File: rtl/ring_pointer.sv
// One-hot ring register holding the rotating priority token.
module ring_pointer #(
  parameter int N = 4
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_load,
  input  logic [N-1:0] i_load_val,
  output logic [N-1:0] o_token
);

  logic [N-1:0] r_token;

  // Token comes out of reset at bit 0 and only moves when a new value is loaded.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)    r_token <= N'(1);
    else if (i_load) r_token <= i_load_val;
  end

  assign o_token = r_token;

endmodule

// File: rtl/ring_token_arbiter.sv
// Round-robin arbiter with rotating one-hot token, dead cycle between owners
// and an optional hold limit that forces the owner off the resource.
module ring_token_arbiter
  import ring_arb_pkg::*;
#(
  parameter  int N        = 4,
  parameter  int MAX_HOLD = 8,
  localparam int ID_W     = $clog2(N)
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic [N-1:0]    i_req,
  output logic [N-1:0]    o_gnt,
  output logic            o_gnt_vld,
  output logic [ID_W-1:0] o_gnt_id,
  output logic [N-1:0]    o_token,
  output logic            o_preempt
);

  localparam int DW    = 2 * N;
  localparam int CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [CNT_W-1:0] HOLD_SAT = CNT_W'(MAX_HOLD);

  state_e           r_state, w_state_nxt;
  logic [N-1:0]     r_gnt, w_gnt_nxt;
  logic [CNT_W-1:0] r_hold, w_hold_nxt;
  logic             r_preempt, w_preempt_nxt;
  logic             w_release;
  logic             w_owner_req;
  logic             w_limit;
  logic [N-1:0]     w_token;
  logic [N-1:0]     w_sel;
  logic [N-1:0]     w_rot;
  logic [MAX_N-N-1:0] w_rot_unused;
  logic [DW-1:0]    w_dbl, w_dbl_pick;

  // Circular search from the token: the low copy keeps only requests at or above
  // the token, the high copy is the wrapped search; lowest set bit wins.
  assign w_dbl      = {i_req, i_req & ~(w_token - N'(1))};
  assign w_dbl_pick = w_dbl & ~(w_dbl - DW'(1));
  assign w_sel      = w_dbl_pick[N-1:0] | w_dbl_pick[DW-1:N];

  assign {w_rot_unused, w_rot} = rotl_onehot(MAX_N'(r_gnt), N);

  assign w_owner_req = |(i_req & r_gnt);
  assign w_limit     = (MAX_HOLD != 0) && (r_hold == HOLD_LIM);

  // Next state, grant and hold counter; a dropped request beats the hold limit.
  always_comb begin
    w_state_nxt   = r_state;
    w_gnt_nxt     = r_gnt;
    w_hold_nxt    = r_hold;
    w_preempt_nxt = 1'b0;
    w_release     = 1'b0;
    case (r_state)
      IDLE, HANDOFF: begin
        w_gnt_nxt  = '0;
        w_hold_nxt = '0;
        if (|i_req) begin
          w_state_nxt = GRANT;
          w_gnt_nxt   = w_sel;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      GRANT: begin
        if (!w_owner_req) begin
          w_state_nxt = HANDOFF;
          w_gnt_nxt   = '0;
          w_release   = 1'b1;
        end else if (w_limit) begin
          w_state_nxt   = HANDOFF;
          w_gnt_nxt     = '0;
          w_release     = 1'b1;
          w_preempt_nxt = 1'b1;
        end else if (r_hold != HOLD_SAT) begin
          w_hold_nxt = r_hold + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
        w_hold_nxt  = '0;
      end
    endcase
  end

  // State and output registers; reset clears a live grant immediately.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state   <= IDLE;
      r_gnt     <= '0;
      r_hold    <= '0;
      r_preempt <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_gnt     <= w_gnt_nxt;
      r_hold    <= w_hold_nxt;
      r_preempt <= w_preempt_nxt;
    end
  end

  ring_pointer #(.N(N)) u_ptr (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (w_release),
    .i_load_val (w_rot),
    .o_token    (w_token)
  );

  assign o_gnt     = r_gnt;
  assign o_gnt_vld = |r_gnt;
  assign o_gnt_id  = ID_W'(onehot2bin(MAX_N'(r_gnt)));
  assign o_token   = w_token;
  assign o_preempt = r_preempt;

endmodule

// File: tb/tb_ring_token_arbiter.sv
// Bench: two arbiters (hold limit 8 and 3) share stimulus; an index-level model
// tracks owner/token per instance and is compared every cycle, plus literals.
module tb_ring_token_arbiter;

  localparam int N = 4;
  localparam int MH [2] = '{8, 3};

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [N-1:0] req = '0;

  logic [N-1:0] gnt_a, tok_a, gnt_b, tok_b;
  logic         vld_a, vld_b, pre_a, pre_b;
  logic [1:0]   id_a, id_b;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  ring_token_arbiter #(.N(N), .MAX_HOLD(8)) u_a (
    .i_clk(clk), .i_reset(rst_n), .i_req(req), .o_gnt(gnt_a), .o_gnt_vld(vld_a),
    .o_gnt_id(id_a), .o_token(tok_a), .o_preempt(pre_a)
  );

  ring_token_arbiter #(.N(N), .MAX_HOLD(3)) u_b (
    .i_clk(clk), .i_reset(rst_n), .i_req(req), .o_gnt(gnt_b), .o_gnt_vld(vld_b),
    .o_gnt_id(id_b), .o_token(tok_b), .o_preempt(pre_b)
  );

  always #5 clk = ~clk;

  // Model: owner index (-1 none), token index, cycles the owner has held gnt.
  int m_own [2];
  int m_tok [2];
  int m_held [2];
  bit m_pre [2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_own[k]  <= -1;
        m_tok[k]  <= 0;
        m_held[k] <= 0;
        m_pre[k]  <= 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        int o, t, h, idx;
        bit p;
        o = m_own[k]; t = m_tok[k]; h = m_held[k]; p = 1'b0;
        if (o >= 0) begin
          if (!req[o]) begin
            t = (o + 1) % N; o = -1;
          end else if (MH[k] != 0 && h == MH[k]) begin
            t = (o + 1) % N; o = -1; p = 1'b1;
          end else begin
            h = h + 1;
          end
        end else if (req != 0) begin
          for (int off = 0; off < N; off++) begin
            idx = (t + off) % N;
            if (o < 0 && req[idx]) begin
              o = idx; h = 1;
            end
          end
        end
        m_own[k]  <= o;
        m_tok[k]  <= t;
        m_held[k] <= h;
        m_pre[k]  <= p;
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < 2; k++) begin
        logic [N-1:0] eg, et, ag, at;
        logic [1:0]   ei, ai;
        logic         ev, ep, av, ap;
        eg = (m_own[k] >= 0) ? N'(1 << m_own[k]) : '0;
        ev = (m_own[k] >= 0);
        ei = (m_own[k] >= 0) ? 2'(m_own[k]) : 2'd0;
        et = N'(1 << m_tok[k]);
        ep = m_pre[k];
        ag = (k == 0) ? gnt_a : gnt_b;
        av = (k == 0) ? vld_a : vld_b;
        ai = (k == 0) ? id_a  : id_b;
        at = (k == 0) ? tok_a : tok_b;
        ap = (k == 0) ? pre_a : pre_b;
        checks++;
        if ({ag, av, ai, at, ap} !== {eg, ev, ei, et, ep}) begin
          errors++;
          $display("FAIL model_cmp inst%0d t=%0t: got gnt=%b vld=%b id=%0d tok=%b pre=%b, expected gnt=%b vld=%b id=%0d tok=%b pre=%b",
                   k, $time, ag, av, ai, at, ap, eg, ev, ei, et, ep);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Apply a request vector across one rising edge; return at the following falling edge.
  task automatic step(input logic [N-1:0] r);
    req = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [N-1:0] t2_req [12] = '{4'b1111, 4'b1110, 4'b1111, 4'b1111, 4'b1101, 4'b1111,
                                4'b1111, 4'b1011, 4'b1111, 4'b1111, 4'b0111, 4'b1111};
  logic [N-1:0] t2_gnt [12] = '{4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0100,
                                4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0001};
  logic [N-1:0] t3_gnt [8]  = '{4'b0001, 4'b0001, 4'b0000, 4'b0100,
                                4'b0100, 4'b0100, 4'b0000, 4'b0001};
  logic         t3_pre [8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    // T1: reset held with all requests up
    #1 rst_n = 1'b0;
    req = 4'b1111;
    cmp_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("t1_rst_gnt", 32'(gnt_b), 32'h0);
    chk("t1_rst_tok", 32'(tok_b), 32'h1);
    chk("t1_rst_pre", 32'(pre_b), 32'h0);
    chk("t1_rst_vld", 32'(vld_a), 32'h0);
    rst_n = 1'b1;
    step(4'b1111);
    chk("t1_first_gnt_b", 32'(gnt_b), 32'h1);
    chk("t1_first_gnt_a", 32'(gnt_a), 32'h1);

    // T2: round robin, each owner keeps gnt 2 cycles
    for (int i = 0; i < 12; i++) begin
      step(t2_req[i]);
      chk($sformatf("t2_gnt_b[%0d]", i), 32'(gnt_b), 32'(t2_gnt[i]));
      chk($sformatf("t2_gnt_a[%0d]", i), 32'(gnt_a), 32'(t2_gnt[i]));
    end

    // T3: hold limit 3 with 0101 held constant
    for (int i = 0; i < 8; i++) begin
      step(4'b0101);
      chk($sformatf("t3_gnt_b[%0d]", i), 32'(gnt_b), 32'(t3_gnt[i]));
      chk($sformatf("t3_pre_b[%0d]", i), 32'(pre_b), 32'(t3_pre[i]));
    end

    rst_n = 1'b0;
    step(4'b0000);
    rst_n = 1'b1;

    // T4: token wrap past bit 3
    step(4'b0100);
    chk("t4_gnt", 32'(gnt_b), 32'h4);
    step(4'b0000);
    chk("t4_tok", 32'(tok_b), 32'h8);
    chk("t4_gap", 32'(gnt_b), 32'h0);
    step(4'b0011);
    chk("t4_wrap_gnt", 32'(gnt_b), 32'h1);
    chk("t4_wrap_id", 32'(id_b), 32'h0);
    chk("t4_wrap_vld", 32'(vld_b), 32'h1);
    step(4'b0000);
    chk("t4_tok2", 32'(tok_b), 32'h2);

    // T5: async reset between edges while 0010 owns with hold_cnt=2
    step(4'b0010);
    step(4'b0010);
    step(4'b0010);
    chk("t5_pre_gnt", 32'(gnt_b), 32'h2);
    chk("t5_pre_id", 32'(id_b), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_async_gnt", 32'(gnt_b), 32'h0);
    chk("t5_async_tok", 32'(tok_b), 32'h1);
    chk("t5_async_pre", 32'(pre_b), 32'h0);
    chk("t5_async_gnt_a", 32'(gnt_a), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // T6: owner drops exactly at the hold limit; single requester wraps token
    step(4'b1000);
    chk("t6_gnt", 32'(gnt_b), 32'h8);
    chk("t6_id", 32'(id_b), 32'h3);
    step(4'b1000);
    step(4'b1000);
    chk("t6_gnt3", 32'(gnt_b), 32'h8);
    step(4'b0000);
    chk("t6_rel_gnt", 32'(gnt_b), 32'h0);
    chk("t6_rel_pre", 32'(pre_b), 32'h0);
    chk("t6_rel_tok", 32'(tok_b), 32'h1);
    step(4'b0000);
    chk("t6_idle_vld", 32'(vld_b), 32'h0);
    step(4'b0100);
    chk("t6_idle_regrant", 32'(gnt_b), 32'h4);
    step(4'b0000);
    step(4'b0000);

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
